// File: rtl/avalon_arb_pkg.sv
// Shared types for the two-master Avalon RAM arbiter.
//   state_t      : sequencer states (IDLE -> [WAIT] -> DONE -> IDLE)
//   M_INSTR/M_DATA: master indices (m0 = instruction, m1 = data)
//   avalon_req_t : request fields captured when a master is granted
package avalon_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic M_INSTR = 1'b0;
    localparam logic M_DATA  = 1'b1;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] writedata;
        logic [3:0]  byteenable;
        logic        read;
        logic        write;
    } avalon_req_t;

    // One-hot grant vector for a master index.
    function automatic logic [1:0] grant_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/avalon_wait_counter.sv
// Loadable, saturating down-counter timing the slave wait states.
//   clk, reset    : clock, synchronous active-high reset (count -> 0)
//   load_i        : load load_val_i (has priority over dec_i)
//   load_val_i    : value to load
//   dec_i         : decrement by one; holds at zero instead of wrapping
//   count_o       : current count
//   zero_o        : count_o == 0
module avalon_wait_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    input  logic          dec_i,
    output logic [CW-1:0] count_o,
    output logic          zero_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;
    assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/avalon_ram_arbiter.sv
// Round-robin arbiter and wait-state sequencer giving the CPU instruction
// master (m0) and data master (m1) exclusive access to one Avalon RAM port.
//   clk, reset          : clock, synchronous active-high reset
//   m0_* / m1_*         : Avalon-MM slave ports facing the two masters
//   s_*                 : Avalon-MM master port to the RAM
//   s_assert_waitrequest: RAM strobe; the RAM transfers on its falling edge,
//                         which happens exactly once per granted transaction
//   grant               : one-hot owner, 00 while idle
module avalon_ram_arbiter #(
    parameter int WAIT_CYCLES = 2,
    parameter int CW          = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [31:0] m0_address,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [31:0] m0_writedata,
    input  logic [3:0]  m0_byteenable,
    output logic        m0_waitrequest,
    output logic [31:0] m0_readdata,

    input  logic [31:0] m1_address,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_writedata,
    input  logic [3:0]  m1_byteenable,
    output logic        m1_waitrequest,
    output logic [31:0] m1_readdata,

    output logic [31:0] s_address,
    output logic        s_read,
    output logic        s_write,
    output logic [31:0] s_writedata,
    output logic [3:0]  s_byteenable,
    output logic        s_assert_waitrequest,
    input  logic [31:0] s_readdata,

    output logic [1:0]  grant
);

    import avalon_arb_pkg::*;

    // Counter preload on entering WAIT; unused when WAIT is skipped.
    localparam logic [CW-1:0] LOAD_VAL = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;  // also the current owner outside IDLE
    avalon_req_t req_q, req_d;

    logic          m0_req, m1_req;
    logic          winner;
    logic          cnt_load, cnt_dec, cnt_zero;
    logic [CW-1:0] cnt_value;

    assign m0_req = m0_read | m0_write;
    assign m1_req = m1_read | m1_write;

    // On a tie the master that did not win last time gets the port.
    always_comb begin
        if (m0_req && m1_req) begin
            winner = ~last_grant_q;
        end else begin
            winner = m1_req ? M_DATA : M_INSTR;
        end
    end

    avalon_wait_counter #(.CW(CW)) u_wait_counter (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (LOAD_VAL),
        .dec_i      (cnt_dec),
        .count_o    (cnt_value),
        .zero_o     (cnt_zero)
    );

    // Next state, arbitration and request capture.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        req_d        = req_q;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    last_grant_d = winner;
                    if (winner == M_DATA) begin
                        req_d = '{m1_address, m1_writedata, m1_byteenable, m1_read, m1_write};
                    end else begin
                        req_d = '{m0_address, m0_writedata, m0_byteenable, m0_read, m0_write};
                    end
                    // Both strobes high is treated as a read.
                    req_d.write = req_d.write & ~req_d.read;
                    cnt_load    = 1'b1;
                    state_d     = (WAIT_CYCLES == 0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (cnt_zero) begin
                    state_d = DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= M_DATA;
            req_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            req_q        <= req_d;
        end
    end

    // Slave side is driven only from the captured request, so master
    // changes after the grant cannot reach the RAM.
    always_comb begin
        grant                = 2'b00;
        s_address            = '0;
        s_read               = 1'b0;
        s_write              = 1'b0;
        s_writedata          = '0;
        s_byteenable         = '0;
        s_assert_waitrequest = 1'b1;
        m0_waitrequest       = 1'b1;
        m1_waitrequest       = 1'b1;
        if ((state_q == WAIT) || (state_q == DONE)) begin
            grant        = grant_onehot(last_grant_q);
            s_address    = req_q.address;
            s_read       = req_q.read;
            s_write      = req_q.write;
            s_writedata  = req_q.writedata;
            s_byteenable = req_q.byteenable;
        end
        if (state_q == DONE) begin
            s_assert_waitrequest = 1'b0;
            m0_waitrequest       = (last_grant_q != M_INSTR);
            m1_waitrequest       = (last_grant_q != M_DATA);
        end
    end

    assign m0_readdata = s_readdata;
    assign m1_readdata = s_readdata;

    // Counter value is only consumed through its zero flag.
    logic unused_cnt;
    assign unused_cnt = ^cnt_value;

endmodule
